// File: rtl/cmp_operand_loader.sv
// Bit-serial operand loader for the keyed difference/equality comparator.
// Deserialises a (key, x, y) frame, then holds it under a valid/ready handshake.
module cmp_operand_loader #(
    parameter int W  = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sin,
    input  logic          sin_valid,
    input  logic          sin_start,
    output logic          sin_ready,
    output logic [0:W-1]  x_o,
    output logic [0:W-1]  y_o,
    output logic          key_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          frame_err,
    output logic [CW-1:0] frame_cnt
);

    localparam int FL = 2 * W + 1;
    localparam int NW = $clog2(FL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [0:W-1]    x_q, x_d;
    logic [0:W-1]    y_q, y_d;
    logic            key_q, key_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            accept;

    assign sin_ready = (state_q != HOLD);
    assign busy      = (state_q != IDLE);
    assign accept    = sin_valid && sin_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            key_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && sin_start) state_d = SHIFT;
            SHIFT:   if (accept && !sin_start && cnt_q == NW'(FL - 1)) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt_q is the number of frame bits already taken; it selects where the next data bit lands.
    always_comb begin
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        key_d   = key_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (accept && sin_start) begin
                    key_d = sin;
                    cnt_d = NW'(1);
                end
            end
            SHIFT: begin
                if (accept && sin_start) begin
                    err_d = 1'b1;
                    x_d   = '0;
                    y_d   = '0;
                    key_d = sin;
                    cnt_d = NW'(1);
                end else if (accept) begin
                    for (int i = 0; i < W; i++) begin
                        if (cnt_q == NW'(i + 1))     x_d[i] = sin;
                        if (cnt_q == NW'(W + 1 + i)) y_d[i] = sin;
                    end
                    cnt_d = cnt_q + NW'(1);
                    if (cnt_q == NW'(FL - 1)) valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    fcnt_d  = fcnt_q + CW'(1);
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign key_o     = key_q;
    assign out_valid = valid_q;
    assign frame_err = err_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_cmp_operand_loader.sv
// Testbench for cmp_operand_loader: directed scenarios plus randomized frames
// checked against a frame-level model (a frame is a 7-bit vector {key, x, y}).
module tb_cmp_operand_loader;

    localparam int W  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sin;
    logic          sin_valid;
    logic          sin_start;
    logic          sin_ready;
    logic [0:W-1]  x_o;
    logic [0:W-1]  y_o;
    logic          key_o;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] exp_cnt;
    logic [6:0]    cur;

    cmp_operand_loader #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_start (sin_start),
        .sin_ready (sin_ready),
        .x_o       (x_o),
        .y_o       (y_o),
        .key_o     (key_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish within budget");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted-candidate bit for a single cycle.
    task automatic applyStimulus(input logic b, input logic start);
        sin       = b;
        sin_start = start;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin       = 1'($urandom);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            sin       = 1'($urandom);
            sin_start = 1'($urandom);
            sin_valid = 1'b0;
            tick();
        end
        sin_start = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input logic [6:0] f);
        checkOutput({tag, ".key"},   32'(key_o),     32'(f[6]));
        checkOutput({tag, ".x"},     32'(x_o),       32'(f[5:3]));
        checkOutput({tag, ".y"},     32'(y_o),       32'(f[2:0]));
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".ready"}, 32'(sin_ready), 32'd0);
        checkOutput({tag, ".cnt"},   32'(frame_cnt), 32'(exp_cnt));
    endtask

    // Send a frame MSB-first; gap is the number of idle cycles between bits (or the max when randomized).
    task automatic sendFrame(input string tag, input logic [6:0] f, input int gap,
                             input bit rand_gap, input bit rand_ready);
        for (int k = 0; k < 7; k++) begin
            if (rand_ready) out_ready = 1'($urandom);
            applyStimulus(f[6-k], (k == 0));
            if (k < 6) begin
                checkOutput({tag, ".early_valid"}, 32'(out_valid), 32'd0);
                idleCycles(rand_gap ? int'($urandom_range(0, gap)) : gap);
            end
        end
        checkFrame(tag, f);
    endtask

    // Hold for 'delay' cycles with sin toggling, then consume the frame.
    task automatic handshake(input string tag, input logic [6:0] f, input int delay);
        out_ready = 1'b0;
        for (int k = 0; k < delay; k++) begin
            sin       = 1'($urandom);
            sin_start = 1'($urandom);
            sin_valid = 1'b1;
            tick();
            checkFrame({tag, ".hold"}, f);
        end
        sin_valid = 1'b0;
        sin_start = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 1'b1;
        checkOutput({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".hs_busy"},  32'(busy),      32'd0);
        checkOutput({tag, ".hs_cnt"},   32'(frame_cnt), 32'(exp_cnt));
        checkOutput({tag, ".hs_x"},     32'(x_o),       32'(f[5:3]));
    endtask

    initial begin
        rstn      = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = '0;
        $display("[TB] start");
        tick();
        tick();
        checkOutput("rst.x",     32'(x_o),       32'd0);
        checkOutput("rst.y",     32'(y_o),       32'd0);
        checkOutput("rst.key",   32'(key_o),     32'd0);
        checkOutput("rst.valid", 32'(out_valid), 32'd0);
        checkOutput("rst.err",   32'(frame_err), 32'd0);
        checkOutput("rst.cnt",   32'(frame_cnt), 32'd0);
        checkOutput("rst.busy",  32'(busy),      32'd0);
        checkOutput("rst.ready", 32'(sin_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Nominal frame with out_ready held high throughout.
        out_ready = 1'b1;
        cur = 7'b1_101_101;
        sendFrame("nom", cur, 0, 1'b0, 1'b0);
        handshake("nom", cur, 0);

        $display("[TB] gapped input");
        cur = 7'b0_110_100;
        sendFrame("gap", cur, 2, 1'b0, 1'b0);
        handshake("gap", cur, 0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        cur = 7'b0_111_001;
        sendFrame("bp", cur, 0, 1'b0, 1'b0);
        handshake("bp", cur, 5);

        $display("[TB] restart");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rs.pre_err", 32'(frame_err), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("rs.err",  32'(frame_err), 32'd1);
        checkOutput("rs.x0",   32'(x_o),       32'd0);
        checkOutput("rs.y0",   32'(y_o),       32'd0);
        checkOutput("rs.key",  32'(key_o),     32'd1);
        checkOutput("rs.busy", 32'(busy),      32'd1);
        cur = 7'b1_011_010;
        for (int k = 5; k >= 0; k--) begin
            applyStimulus(cur[k], 1'b0);
            if (k == 5) checkOutput("rs.err_clear", 32'(frame_err), 32'd0);
        end
        checkFrame("rs", cur);
        handshake("rs", cur, 1);

        $display("[TB] stray bits in idle");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("stray.busy",  32'(busy),      32'd0);
            checkOutput("stray.err",   32'(frame_err), 32'd0);
            checkOutput("stray.valid", 32'(out_valid), 32'd0);
            checkOutput("stray.x",     32'(x_o),       32'(cur[5:3]));
        end

        $display("[TB] exhaustive frames with random gaps");
        for (int v = 0; v < 128; v++) begin
            cur = 7'(v);
            sendFrame("exh", cur, 1, 1'b1, 1'b1);
            handshake("exh", cur, int'($urandom_range(0, 2)));
        end

        $display("[TB] random frames up to counter wrap");
        while (exp_cnt != 8'd255) begin
            cur = 7'($urandom);
            sendFrame("rnd", cur, 2, 1'b1, 1'b1);
            handshake("rnd", cur, int'($urandom_range(0, 3)));
        end
        cur = 7'($urandom);
        sendFrame("wrap", cur, 0, 1'b0, 1'b0);
        handshake("wrap", cur, 0);
        checkOutput("wrap.zero", 32'(frame_cnt), 32'd0);

        $display("[TB] async reset mid-frame");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst.key",  32'(key_o),     32'd0);
        checkOutput("arst.x",    32'(x_o),       32'd0);
        checkOutput("arst.busy", 32'(busy),      32'd0);
        checkOutput("arst.cnt",  32'(frame_cnt), 32'd0);
        #3;
        rstn = 1'b1;
        exp_cnt = '0;
        tick();
        cur = 7'b1_010_110;
        sendFrame("post", cur, 0, 1'b0, 1'b0);
        handshake("post", cur, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
